// File: rtl/correlator_block_gen.sv
// Time-multiplexed 1-bit complex correlator: NCORR lanes x TRATE slots accumulated
// into an NBANK-deep visibility buffer with bank swap, clear pass, saturation and readback.
module correlator_block_gen #(
    parameter int NCORR = 4,
    parameter int TRATE = 12,
    parameter int SBITS = 4,
    parameter int ACCUM = 24,
    parameter int BBITS = 3,
    parameter int LBITS = 2,
    parameter int ABITS = BBITS + SBITS + LBITS + 1
) (
    input  logic             clk_x,
    input  logic             rst_n,
    input  logic             sw_i,
    input  logic             en_i,
    input  logic [NCORR-1:0] xr_i,
    input  logic [NCORR-1:0] xi_i,
    input  logic [NCORR-1:0] yr_i,
    input  logic [NCORR-1:0] yi_i,
    input  logic             rd_req_i,
    input  logic [ABITS-1:0] rd_adr_i,
    output logic             rd_vld_o,
    output logic [ACCUM-1:0] rd_dat_o,
    output logic [BBITS-1:0] bank_o,
    output logic             ovf_o,
    output logic             clear_o
);
    localparam int NENT = 2 ** (BBITS + SBITS);
    localparam logic [SBITS-1:0] LAST_SLOT = SBITS'(TRATE - 1);

    // Returns {clamped, value}; a clear pass ignores the stale accumulator.
    function automatic logic [ACCUM:0] sat_add(input logic [ACCUM-1:0] acc,
                                               input logic [1:0] inc, input logic clr);
        logic [ACCUM:0] full;
        full = clr ? {{(ACCUM-1){1'b0}}, inc} : {1'b0, acc} + {{(ACCUM-1){1'b0}}, inc};
        if (full[ACCUM]) return {1'b1, {ACCUM{1'b1}}};
        return {1'b0, full[ACCUM-1:0]};
    endfunction

    logic [SBITS-1:0] slot;
    logic             pending, sticky, wrap, swap_now, clamp;
    logic [1:0]       re_inc [NCORR];
    logic [1:0]       im_inc [NCORR];

    logic [ACCUM-1:0] mem_re [NCORR][NENT];
    logic [ACCUM-1:0] mem_im [NCORR][NENT];

    logic                   s1_vld, s1_clear, s1_retire;
    logic [BBITS+SBITS-1:0] s1_adr;
    logic [1:0]             s1_re_inc [NCORR];
    logic [1:0]             s1_im_inc [NCORR];
    logic [ACCUM-1:0]       s1_re_acc [NCORR];
    logic [ACCUM-1:0]       s1_im_acc [NCORR];
    logic [ACCUM:0]         re_res [NCORR];
    logic [ACCUM:0]         im_res [NCORR];

    assign wrap     = en_i && (slot == LAST_SLOT);
    assign swap_now = wrap && (sw_i || pending);

    always_comb begin
        for (int l = 0; l < NCORR; l++) begin
            re_inc[l] = {1'b0, xr_i[l] == yr_i[l]} + {1'b0, xi_i[l] == yi_i[l]};
            im_inc[l] = {1'b0, xi_i[l] == yr_i[l]} + {1'b0, xr_i[l] != yi_i[l]};
        end
    end

    // NOTE: every always_comb output gets a value before any condition, so no latch is inferred.
    always_comb begin
        clamp = 1'b0;
        for (int l = 0; l < NCORR; l++) begin
            re_res[l] = sat_add(s1_re_acc[l], s1_re_inc[l], s1_clear);
            im_res[l] = sat_add(s1_im_acc[l], s1_im_inc[l], s1_clear);
            clamp     = clamp | re_res[l][ACCUM] | im_res[l][ACCUM];
        end
    end

    // NOTE: the accumulator RAM and its datapath registers carry no reset; the clear pass defines them.
    always_ff @(posedge clk_x) begin
        if (en_i) begin
            s1_adr <= {bank_o, slot};
            for (int l = 0; l < NCORR; l++) begin
                s1_re_inc[l] <= re_inc[l];
                s1_im_inc[l] <= im_inc[l];
                s1_re_acc[l] <= mem_re[l][{bank_o, slot}];
                s1_im_acc[l] <= mem_im[l][{bank_o, slot}];
            end
        end
        if (s1_vld) begin
            for (int l = 0; l < NCORR; l++) begin
                mem_re[l][s1_adr] <= re_res[l][ACCUM-1:0];
                mem_im[l][s1_adr] <= im_res[l][ACCUM-1:0];
            end
        end
    end

    // ovf_o is updated with the retired bank's final write-back, one cycle after bank_o moves.
    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            slot      <= '0;
            pending   <= 1'b0;
            bank_o    <= '0;
            clear_o   <= 1'b1;
            sticky    <= 1'b0;
            ovf_o     <= 1'b0;
            s1_vld    <= 1'b0;
            s1_clear  <= 1'b0;
            s1_retire <= 1'b0;
        end else begin
            s1_vld <= en_i;
            if (en_i) begin
                s1_clear  <= clear_o;
                s1_retire <= swap_now;
                slot      <= wrap ? '0 : slot + 1'b1;
            end
            if (swap_now)  pending <= 1'b0;
            else if (sw_i) pending <= 1'b1;
            if (swap_now) bank_o <= bank_o + 1'b1;
            if (wrap)     clear_o <= swap_now;
            if (s1_vld && s1_retire) begin
                ovf_o  <= sticky | clamp;
                sticky <= 1'b0;
            end else if (s1_vld && clamp) begin
                sticky <= 1'b1;
            end
        end
    end

    logic             rb_vld;
    logic [ABITS-1:0] rb_adr;
    logic [BBITS-1:0] rb_bank;
    logic [SBITS-1:0] rb_slot;
    logic [LBITS-1:0] rb_lane;
    logic [ACCUM-1:0] rb_dat;

    assign rb_bank = rb_adr[ABITS-1 -: BBITS];
    assign rb_slot = rb_adr[LBITS+1 +: SBITS];
    assign rb_lane = rb_adr[1 +: LBITS];

    always_comb begin
        rb_dat = '0;
        if (int'(rb_slot) < TRATE) begin
            for (int l = 0; l < NCORR; l++) begin
                if (rb_lane == LBITS'(l))
                    rb_dat = rb_adr[0] ? mem_im[l][{rb_bank, rb_slot}] : mem_re[l][{rb_bank, rb_slot}];
            end
        end
    end

    always_ff @(posedge clk_x or negedge rst_n) begin
        if (!rst_n) begin
            rb_vld   <= 1'b0;
            rb_adr   <= '0;
            rd_vld_o <= 1'b0;
            rd_dat_o <= '0;
        end else begin
            rb_vld   <= rd_req_i;
            rd_vld_o <= rb_vld;
            if (rd_req_i) rb_adr   <= rd_adr_i;
            if (rb_vld)   rd_dat_o <= rb_dat;
        end
    end

endmodule

// File: tb/tb_correlator_block_gen.sv
// Bench for correlator_block_gen: two instances (ACCUM=24 and ACCUM=4) share stimulus and are
// checked against an array-based visibility model; LBITS=3 so out-of-range lanes are addressable.
module tb_correlator_block_gen;
    localparam int NC = 4;
    localparam int TR = 12;
    localparam int SB = 4;
    localparam int BB = 3;
    localparam int LB = 3;
    localparam int AB = BB + SB + LB + 1;

    logic          clk_x = 1'b0;
    logic          rst_n = 1'b0;
    logic          sw = 1'b0, en = 1'b0, rd_req = 1'b0;
    logic [NC-1:0] xr = '0, xi = '0, yr = '0, yi = '0;
    logic [AB-1:0] rd_adr = '0;
    logic          rd_vld_a, rd_vld_b, ovf_a, ovf_b, clear_a, clear_b;
    logic [23:0]   rd_dat_a;
    logic [3:0]    rd_dat_b;
    logic [BB-1:0] bank_a, bank_b;

    int checks = 0;
    int failures = 0;

    correlator_block_gen #(.NCORR(NC), .TRATE(TR), .SBITS(SB), .ACCUM(24), .BBITS(BB), .LBITS(LB)) dut_a (
        .clk_x(clk_x), .rst_n(rst_n), .sw_i(sw), .en_i(en), .xr_i(xr), .xi_i(xi), .yr_i(yr), .yi_i(yi),
        .rd_req_i(rd_req), .rd_adr_i(rd_adr), .rd_vld_o(rd_vld_a), .rd_dat_o(rd_dat_a),
        .bank_o(bank_a), .ovf_o(ovf_a), .clear_o(clear_a));

    correlator_block_gen #(.NCORR(NC), .TRATE(TR), .SBITS(SB), .ACCUM(4), .BBITS(BB), .LBITS(LB)) dut_b (
        .clk_x(clk_x), .rst_n(rst_n), .sw_i(sw), .en_i(en), .xr_i(xr), .xi_i(xi), .yr_i(yr), .yi_i(yi),
        .rd_req_i(rd_req), .rd_adr_i(rd_adr), .rd_vld_o(rd_vld_b), .rd_dat_o(rd_dat_b),
        .bank_o(bank_b), .ovf_o(ovf_b), .clear_o(clear_b));

    always #5 clk_x = ~clk_x;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog");
    end

    // Visibility model: [instance][bank][slot][lane][re/im]
    int  m_val [2][8][TR][NC][2];
    bit  m_ok [8][TR][NC];
    int  max_v [2] = '{16777215, 15};
    int  m_bank, m_slot;
    bit  m_clear, m_pend;
    bit  m_sticky [2];
    bit  m_ovf [2];

    task automatic model_reset();
        m_bank = 0; m_slot = 0; m_clear = 1; m_pend = 0;
        for (int k = 0; k < 2; k++) begin m_sticky[k] = 0; m_ovf[k] = 0; end
        for (int b = 0; b < 8; b++)
            for (int s = 0; s < TR; s++)
                for (int l = 0; l < NC; l++) m_ok[b][s][l] = 0;
    endtask

    task automatic model_step(input bit s_req, input logic [NC-1:0] a_r, a_i, b_r, b_i);
        bit wrap, swap;
        for (int l = 0; l < NC; l++) begin
            int inc [2];
            inc[0] = int'(a_r[l] == b_r[l]) + int'(a_i[l] == b_i[l]);
            inc[1] = int'(a_i[l] == b_r[l]) + int'(a_r[l] != b_i[l]);
            for (int k = 0; k < 2; k++)
                for (int c = 0; c < 2; c++) begin
                    int v;
                    v = m_clear ? inc[c] : m_val[k][m_bank][m_slot][l][c] + inc[c];
                    if (v > max_v[k]) begin v = max_v[k]; m_sticky[k] = 1; end
                    m_val[k][m_bank][m_slot][l][c] = v;
                end
            m_ok[m_bank][m_slot][l] = 1;
        end
        wrap = (m_slot == TR - 1);
        swap = wrap && (s_req || m_pend);
        if (swap) begin
            m_pend = 0;
            m_bank = (m_bank + 1) % 8;
            for (int k = 0; k < 2; k++) begin m_ovf[k] = m_sticky[k]; m_sticky[k] = 0; end
        end else if (s_req) begin
            m_pend = 1;
        end
        if (wrap) m_clear = swap;
        m_slot = wrap ? 0 : m_slot + 1;
    endtask

    // Drive one cycle from a negedge; returns at the next negedge with outputs settled.
    task automatic cycle(input bit e, input bit s, input logic [NC-1:0] a_r, a_i, b_r, b_i);
        en = e; sw = s; xr = a_r; xi = a_i; yr = b_r; yi = b_i;
        if (e) model_step(s, a_r, a_i, b_r, b_i);
        @(negedge clk_x);
        en = 1'b0; sw = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk_x);
    endtask

    function automatic logic [AB-1:0] adr(input int b, input int s, input int l, input int im);
        return {BB'(b), SB'(s), LB'(l), 1'(im)};
    endfunction

    logic [AB-1:0] rq_adr [$];
    logic [31:0]   ex_a [$], ex_b [$], cap_da [$], cap_db [$];
    logic          cap_va [$], cap_vb [$];

    task automatic reads_reset();
        rq_adr.delete(); ex_a.delete(); ex_b.delete();
    endtask

    task automatic push_const(input int b, input int re_a, input int re_b, input int im_a, input int im_b);
        for (int s = 0; s < TR; s++)
            for (int l = 0; l < NC; l++) begin
                rq_adr.push_back(adr(b, s, l, 0)); ex_a.push_back(re_a); ex_b.push_back(re_b);
                rq_adr.push_back(adr(b, s, l, 1)); ex_a.push_back(im_a); ex_b.push_back(im_b);
            end
    endtask

    task automatic push_model(input int b, input int s, input int l, input int im);
        rq_adr.push_back(adr(b, s, l, im));
        ex_a.push_back(m_val[0][b][s][l][im]);
        ex_b.push_back(m_val[1][b][s][l][im]);
    endtask

    task automatic push_model_bank(input int b);
        for (int s = 0; s < TR; s++)
            for (int l = 0; l < NC; l++)
                if (m_ok[b][s][l]) begin push_model(b, s, l, 0); push_model(b, s, l, 1); end
    endtask

    // Issues rq_adr back-to-back; sample i is taken before request i is driven.
    task automatic do_reads();
        int n;
        n = rq_adr.size();
        cap_da.delete(); cap_db.delete(); cap_va.delete(); cap_vb.delete();
        for (int i = 0; i < n + 3; i++) begin
            cap_va.push_back(rd_vld_a); cap_vb.push_back(rd_vld_b);
            cap_da.push_back(32'(rd_dat_a)); cap_db.push_back(32'(rd_dat_b));
            rd_req = (i < n);
            rd_adr = (i < n) ? rq_adr[i] : '0;
            @(negedge clk_x);
        end
        rd_req = 1'b0;
    endtask

    task automatic test_reset();
        idle(2);
        checks++;
        if ({bank_a, clear_a, ovf_a, rd_vld_a} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_status_a: got bank=%0d clear=%b ovf=%b vld=%b, expected 0 1 0 0", bank_a, clear_a, ovf_a, rd_vld_a);
        end
        checks++;
        if ({bank_b, clear_b, ovf_b, rd_vld_b} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL reset_status_b: got bank=%0d clear=%b ovf=%b vld=%b, expected 0 1 0 0", bank_b, clear_b, ovf_b, rd_vld_b);
        end
        checks++;
        if (rd_dat_a !== 24'd0 || rd_dat_b !== 4'd0) begin
            failures++; $display("FAIL reset_rd_dat: got a=%0h b=%0h, expected 0 0", rd_dat_a, rd_dat_b);
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_basic();
        for (int i = 0; i < 2 * TR; i++) begin
            cycle(1, 0, '1, '1, '1, '1);
            checks++;
            if (bank_a !== 3'd0 || bank_b !== 3'd0 || clear_a !== (i < TR - 1) || clear_b !== (i < TR - 1)) begin
                failures++; $display("FAIL basic_status cyc=%0d: got bank=%0d clear=%b, expected bank=0 clear=%b", i, bank_a, clear_a, i < TR - 1);
            end
        end
        reads_reset();
        push_const(0, 4, 4, 2, 2);
        do_reads();
        for (int j = 0; j < rq_adr.size(); j++) begin
            checks++;
            if (cap_da[j+2] !== ex_a[j] || cap_db[j+2] !== ex_b[j]) begin
                failures++; $display("FAIL basic_rd adr=%h: got a=%0d b=%0d, expected a=%0d b=%0d", rq_adr[j], cap_da[j+2], cap_db[j+2], ex_a[j], ex_b[j]);
            end
        end
    endtask

    // Third pass into bank 0 carries the request; the fourth is the clear pass of bank 1.
    task automatic test_swap();
        for (int s = 0; s < TR; s++) begin
            cycle(1, s == 5, '1, '1, '1, '1);
            checks++;
            if (bank_a !== 3'((s == TR - 1) ? 1 : 0) || clear_a !== (s == TR - 1) || bank_b !== bank_a) begin
                failures++; $display("FAIL swap_status slot=%0d: got bank=%0d clear=%b, expected bank=%0d clear=%b", s, bank_a, clear_a, (s == TR - 1) ? 1 : 0, s == TR - 1);
            end
        end
        for (int s = 0; s < TR; s++) begin
            cycle(1, 0, '1, '1, '1, '1);
            checks++;
            if (bank_a !== 3'd1 || clear_a !== (s < TR - 1)) begin
                failures++; $display("FAIL swap_clear_pass slot=%0d: got bank=%0d clear=%b, expected bank=1 clear=%b", s, bank_a, clear_a, s < TR - 1);
            end
        end
        reads_reset();
        push_const(0, 6, 6, 3, 3);
        push_const(1, 2, 2, 1, 1);
        do_reads();
        for (int j = 0; j < rq_adr.size(); j++) begin
            checks++;
            if (cap_da[j+2] !== ex_a[j] || cap_db[j+2] !== ex_b[j]) begin
                failures++; $display("FAIL swap_rd adr=%h: got a=%0d b=%0d, expected a=%0d b=%0d", rq_adr[j], cap_da[j+2], cap_db[j+2], ex_a[j], ex_b[j]);
            end
        end
    endtask

    task automatic test_coincident();
        for (int s = 0; s < TR; s++) begin
            cycle(1, s == TR - 1, NC'($urandom), NC'($urandom), NC'($urandom), NC'($urandom));
            checks++;
            if (bank_a !== 3'((s == TR - 1) ? 2 : 1) || bank_b !== bank_a) begin
                failures++; $display("FAIL coincident_bank slot=%0d: got %0d, expected %0d", s, bank_a, (s == TR - 1) ? 2 : 1);
            end
        end
        checks++;
        if (clear_a !== 1'b1 || clear_b !== 1'b1) begin
            failures++; $display("FAIL coincident_clear: got %b, expected 1", clear_a);
        end
    endtask

    task automatic test_double_sw();
        for (int s = 0; s < TR; s++) begin
            cycle(1, s == 2 || s == 7, NC'($urandom), NC'($urandom), NC'($urandom), NC'($urandom));
            checks++;
            if (bank_a !== 3'((s == TR - 1) ? 3 : 2)) begin
                failures++; $display("FAIL double_sw_bank slot=%0d: got %0d, expected %0d", s, bank_a, (s == TR - 1) ? 3 : 2);
            end
        end
        // Clear pass of bank 3 with all-ones lanes; the saturation test continues in this bank.
        for (int s = 0; s < TR; s++) cycle(1, 0, '1, '1, '1, '1);
        checks++;
        if (bank_a !== 3'd3 || bank_b !== 3'd3 || clear_a !== 1'b0) begin
            failures++; $display("FAIL double_sw_single_step: got bank=%0d clear=%b, expected bank=3 clear=0", bank_a, clear_a);
        end
    endtask

    // Bank 3 receives ten all-ones passes in total: re=20 (15 when 4-bit), im=10.
    task automatic test_saturation();
        for (int p = 0; p < 9; p++)
            for (int s = 0; s < TR; s++) cycle(1, p == 8 && s == 0, '1, '1, '1, '1);
        idle(1);
        checks++;
        if (bank_a !== 3'd4 || ovf_a !== 1'b0 || ovf_b !== 1'b1) begin
            failures++; $display("FAIL sat_ovf_set: got bank=%0d ovf_a=%b ovf_b=%b, expected 4 0 1", bank_a, ovf_a, ovf_b);
        end
        reads_reset();
        push_const(3, 20, 15, 10, 10);
        do_reads();
        for (int j = 0; j < rq_adr.size(); j++) begin
            checks++;
            if (cap_da[j+2] !== ex_a[j] || cap_db[j+2] !== ex_b[j]) begin
                failures++; $display("FAIL sat_rd adr=%h: got a=%0d b=%0d, expected a=%0d b=%0d", rq_adr[j], cap_da[j+2], cap_db[j+2], ex_a[j], ex_b[j]);
            end
        end
        for (int s = 0; s < TR; s++) begin
            cycle(1, s == 3, '1, '1, '1, '1);
            if (s == 6) begin
                checks++;
                if (ovf_b !== 1'b1) begin
                    failures++; $display("FAIL sat_ovf_hold: got %b, expected 1", ovf_b);
                end
            end
        end
        idle(1);
        checks++;
        if (bank_a !== 3'd5 || ovf_a !== 1'b0 || ovf_b !== 1'b0) begin
            failures++; $display("FAIL sat_ovf_clear: got bank=%0d ovf_a=%b ovf_b=%b, expected 5 0 0", bank_a, ovf_a, ovf_b);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 72; i++) begin
            bit e, s;
            e = ($urandom_range(3) != 0);
            s = e && ($urandom_range(15) == 0);
            cycle(e, s, NC'($urandom), NC'($urandom), NC'($urandom), NC'($urandom));
            checks++;
            if (bank_a !== 3'(m_bank) || bank_b !== 3'(m_bank) || clear_a !== m_clear || clear_b !== m_clear) begin
                failures++; $display("FAIL random_status i=%0d: got bank=%0d clear=%b, expected bank=%0d clear=%b", i, bank_a, clear_a, m_bank, m_clear);
            end
        end
        idle(2);
        checks++;
        if (ovf_a !== m_ovf[0] || ovf_b !== m_ovf[1]) begin
            failures++; $display("FAIL random_ovf: got a=%b b=%b, expected a=%b b=%b", ovf_a, ovf_b, m_ovf[0], m_ovf[1]);
        end
        reads_reset();
        for (int b = 0; b < 8; b++) push_model_bank(b);
        do_reads();
        for (int j = 0; j < rq_adr.size(); j++) begin
            checks++;
            if (cap_da[j+2] !== ex_a[j] || cap_db[j+2] !== ex_b[j]) begin
                failures++; $display("FAIL random_rd adr=%h: got a=%0d b=%0d, expected a=%0d b=%0d", rq_adr[j], cap_da[j+2], cap_db[j+2], ex_a[j], ex_b[j]);
            end
        end
    endtask

    task automatic test_back_to_back();
        reads_reset();
        push_model(3, 0, 0, 0);
        push_model(3, 4, 1, 1);
        rq_adr.push_back(adr(3, 2, 5, 0)); ex_a.push_back(0); ex_b.push_back(0);
        push_model(3, 11, 3, 0);
        rq_adr.push_back(adr(3, 13, 1, 1)); ex_a.push_back(0); ex_b.push_back(0);
        push_model(3, 7, 2, 1);
        rq_adr.push_back(adr(3, 5, 4, 0)); ex_a.push_back(0); ex_b.push_back(0);
        push_model(3, 9, 0, 0);
        do_reads();
        for (int i = 0; i < rq_adr.size() + 3; i++) begin
            checks++;
            if (cap_va[i] !== (i >= 2 && i < rq_adr.size() + 2) || cap_vb[i] !== cap_va[i]) begin
                failures++; $display("FAIL b2b_vld sample=%0d: got a=%b b=%b, expected %b", i, cap_va[i], cap_vb[i], i >= 2 && i < rq_adr.size() + 2);
            end
        end
        for (int j = 0; j < rq_adr.size(); j++) begin
            checks++;
            if (cap_da[j+2] !== ex_a[j] || cap_db[j+2] !== ex_b[j]) begin
                failures++; $display("FAIL b2b_rd adr=%h: got a=%0d b=%0d, expected a=%0d b=%0d", rq_adr[j], cap_da[j+2], cap_db[j+2], ex_a[j], ex_b[j]);
            end
        end
    endtask

    task automatic test_reset_mid_pass();
        while (m_slot != 7) cycle(1, 0, NC'($urandom), NC'($urandom), NC'($urandom), NC'($urandom));
        en = 1'b1; xr = NC'($urandom); xi = NC'($urandom); yr = NC'($urandom); yi = NC'($urandom);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({bank_a, clear_a, ovf_a, rd_vld_a} !== {3'd0, 1'b1, 1'b0, 1'b0} ||
            {bank_b, clear_b, ovf_b, rd_vld_b} !== {3'd0, 1'b1, 1'b0, 1'b0}) begin
            failures++; $display("FAIL midreset_status: got bank=%0d/%0d clear=%b/%b ovf=%b/%b vld=%b/%b, expected 0 1 0 0",
                                 bank_a, bank_b, clear_a, clear_b, ovf_a, ovf_b, rd_vld_a, rd_vld_b);
        end
        checks++;
        if (rd_dat_a !== 24'd0 || rd_dat_b !== 4'd0) begin
            failures++; $display("FAIL midreset_rd_dat: got a=%0h b=%0h, expected 0 0", rd_dat_a, rd_dat_b);
        end
        @(negedge clk_x);
        en = 1'b0;
        rst_n = 1'b1;
        model_reset();
        for (int s = 0; s < TR; s++) begin
            cycle(1, 0, NC'($urandom), NC'($urandom), NC'($urandom), NC'($urandom));
            checks++;
            if (bank_a !== 3'd0 || clear_a !== (s < TR - 1) || clear_b !== clear_a) begin
                failures++; $display("FAIL midreset_pass slot=%0d: got bank=%0d clear=%b, expected bank=0 clear=%b", s, bank_a, clear_a, s < TR - 1);
            end
        end
        reads_reset();
        push_model_bank(0);
        do_reads();
        for (int j = 0; j < rq_adr.size(); j++) begin
            checks++;
            if (cap_da[j+2] !== ex_a[j] || cap_db[j+2] !== ex_b[j]) begin
                failures++; $display("FAIL midreset_rd adr=%h: got a=%0d b=%0d, expected a=%0d b=%0d", rq_adr[j], cap_da[j+2], cap_db[j+2], ex_a[j], ex_b[j]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_swap();
        test_coincident();
        test_double_sw();
        test_saturation();
        test_random();
        test_back_to_back();
        test_reset_mid_pass();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
